// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential divider.
//   - DIV_WIDTH     : default operand/result width.
//   - DIV_ZERO_QUOT : quotient reported for a zero divisor (all ones).
//   - div_state_e   : divider FSM encoding (idle / iterating / result pulse).
//   - cla4()        : 4-bit carry-lookahead add slice, {carry_out, sum}.
package alu_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } div_state_e;

   // Same slice structure as the adder datapath: full lookahead inside 4 bits.
   function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | ((&p) & cin);
      return {c[4], p ^ c[3:0]};
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//   i_rem_acc / i_quo_acc : current partial remainder / quotient working register
//   i_divisor             : latched divisor
//   o_rem_acc / o_quo_acc : working register after shift and trial subtract
module div_step
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem_acc,
   input  logic [WIDTH-1:0] i_quo_acc,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem_acc,
   output logic [WIDTH-1:0] o_quo_acc
);

   // Trial subtract is WIDTH+1 bits, padded up to whole 4-bit slices.
   localparam int unsigned NSLICE = (WIDTH + 4) / 4;
   localparam int unsigned NBITS  = 4 * NSLICE;

   logic [NBITS-1:0] w_a;
   logic [NBITS-1:0] w_b_n;
   logic [NBITS-1:0] w_sum;
   logic [NSLICE:0]  w_carry;
   logic             w_no_borrow;
   logic             w_unused_sum;

   // Shifted remainder keeps the bit that falls out of rem_acc, so a set MSB
   // can never produce a false borrow.
   assign w_a        = NBITS'({i_rem_acc, i_quo_acc[WIDTH-1]});
   assign w_b_n      = ~NBITS'(i_divisor);
   assign w_carry[0] = 1'b1;

   for (genvar s = 0; s < NSLICE; s++) begin : g_slice
      assign {w_carry[s+1], w_sum[4*s +: 4]} = cla4(w_a[4*s +: 4], w_b_n[4*s +: 4], w_carry[s]);
   end

   // A + ~B + 1 carries out exactly when A >= B.
   assign w_no_borrow  = w_carry[NSLICE];
   assign w_unused_sum = ^w_sum[NBITS-1:WIDTH];

   // On success the difference is below the divisor, so it fits WIDTH bits.
   assign o_rem_acc = w_no_borrow ? w_sum[WIDTH-1:0] : w_a[WIDTH-1:0];
   assign o_quo_acc = {i_quo_acc[WIDTH-2:0], w_no_borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request, accepted only in idle or the done cycle
//   dividend, divisor   : operands, captured on the accepting edge
//   busy                : high during the WIDTH iteration cycles
//   done                : one-cycle pulse, results valid in that cycle
//   quotient, remainder : results, held until the next accepted start
//   div_by_zero         : captured divisor was zero (quotient all ones)
module seq_divider
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_e       r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d;
   logic [WIDTH-1:0] r_divisor, w_divisor_d;
   logic [WIDTH-1:0] r_rem_acc, w_rem_acc_d;
   logic [WIDTH-1:0] r_quo_acc, w_quo_acc_d;
   logic [WIDTH-1:0] r_quotient, w_quotient_d;
   logic [WIDTH-1:0] r_remainder, w_remainder_d;
   logic             r_dbz, w_dbz_d;

   logic [WIDTH-1:0] w_step_rem;
   logic [WIDTH-1:0] w_step_quo;
   logic             w_accept;
   logic             w_zero_in;
   logic             w_last;

   assign w_accept  = start && (r_state == StIdle || r_state == StDone);
   assign w_zero_in = (divisor == '0);
   assign w_last    = (r_cnt == CNT_W'(1));

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem_acc (r_rem_acc),
      .i_quo_acc (r_quo_acc),
      .i_divisor (r_divisor),
      .o_rem_acc (w_step_rem),
      .o_quo_acc (w_step_quo)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_d;
   end

   // Next-state logic
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle, StDone: begin
            if (w_accept) w_state_d = w_zero_in ? StDone : StCalc;
            else          w_state_d = StIdle;
         end
         StCalc:  if (w_last) w_state_d = StDone;
         default: w_state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (r_state == StCalc);
      done = (r_state == StDone);
   end

   // Datapath next-state
   always_comb begin
      w_cnt_d       = r_cnt;
      w_divisor_d   = r_divisor;
      w_rem_acc_d   = r_rem_acc;
      w_quo_acc_d   = r_quo_acc;
      w_quotient_d  = r_quotient;
      w_remainder_d = r_remainder;
      w_dbz_d       = r_dbz;
      if (w_accept) begin
         w_divisor_d = divisor;
         w_rem_acc_d = '0;
         w_quo_acc_d = dividend;
         w_dbz_d     = w_zero_in;
         if (w_zero_in) begin
            w_quotient_d  = {WIDTH{DIV_ZERO_QUOT[0]}};
            w_remainder_d = dividend;
            w_cnt_d       = '0;
         end else begin
            w_cnt_d = CNT_W'(WIDTH);
         end
      end else if (r_state == StCalc) begin
         w_rem_acc_d = w_step_rem;
         w_quo_acc_d = w_step_quo;
         w_cnt_d     = r_cnt - CNT_W'(1);
         if (w_last) begin
            w_quotient_d  = w_step_quo;
            w_remainder_d = w_step_rem;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_divisor   <= '0;
         r_rem_acc   <= '0;
         r_quo_acc   <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_d;
         r_divisor   <= w_divisor_d;
         r_rem_acc   <= w_rem_acc_d;
         r_quo_acc   <= w_quo_acc_d;
         r_quotient  <= w_quotient_d;
         r_remainder <= w_remainder_d;
         r_dbz       <= w_dbz_d;
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, hand-written corner
// sequences (ignored restart, back-to-back start, reset abort) and a random
// regression against a plain-arithmetic reference model.
module tb_seq_divider;

   localparam int unsigned W = 32;
   localparam int MAX_LAT = 60;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_divider #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: unsigned division from the arithmetic definition.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic dbz);
      if (b == 0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         dbz = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         dbz = 1'b0;
      end
   endtask

   // Drive a request so that the next rising edge accepts it.
   task automatic launch(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      dividend = a;
      divisor = b;
      @(posedge clk);
   endtask

   // Called at the accepting edge; returns at the negedge of the done cycle.
   // lat counts rising edges with the accepting edge as 1.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat = 1;
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      while (!done && lat < MAX_LAT) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("done_within_bound", done, 1);
   endtask

   initial begin
      logic [31:0] eq, er, a, b;
      logic        edbz;
      int          lat, bc;

      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
      vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
      vecs[2] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 33};
      vecs[3] = '{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
      vecs[4] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33};
      vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
      vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
      vecs[7] = '{32'h8000_0000,  32'd2,          32'h4000_0000,  32'd0,          1'b0, 33};
      vecs[8] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0, 33};
      vecs[9] = '{32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 33};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_quotient", quotient, 0);
      check("reset_remainder", remainder, 0);
      check("reset_dbz", div_by_zero, 0);
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 10; i++) begin
         launch(vecs[i].a, vecs[i].b);
         wait_done(lat, bc);
         check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
         check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
         check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].dbz);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_busy_cycles", i), bc, (vecs[i].dbz ? 0 : W));
         @(negedge clk);
         check($sformatf("vec%0d_done_one_cycle", i), done, 0);
         check($sformatf("vec%0d_quotient_held", i), quotient, vecs[i].q);
      end

      // Reset mid-operation: outputs clear at once, no done pulse.
      launch(32'd1000, 32'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_dbz", div_by_zero, 0);
      bc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 3) rst_n = 1'b1;
         if (done || busy) bc++;
      end
      check("abort_no_activity", bc, 0);
      launch(32'd1000, 32'd3);
      wait_done(lat, bc);
      check("after_reset_quotient", quotient, 333);
      check("after_reset_remainder", remainder, 1);

      // Start while busy is ignored; start in the done cycle is accepted.
      launch(32'd100, 32'd7);
      lat = 1;
      bc = 0;
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < MAX_LAT) begin
         if (busy) bc++;
         @(posedge clk);
         lat++;
         @(negedge clk);
         start = (lat == 10);
         if (start) begin
            dividend = 32'd9;
            divisor = 32'd3;
         end
      end
      start = 1'b0;
      check("ignored_restart_latency", lat, 33);
      check("ignored_restart_busy_cycles", bc, W);
      check("ignored_restart_quotient", quotient, 14);
      check("ignored_restart_remainder", remainder, 2);
      start = 1'b1;
      dividend = 32'd9;
      divisor = 32'd3;
      @(posedge clk);
      wait_done(lat, bc);
      check("back_to_back_latency", lat, 33);
      check("back_to_back_quotient", quotient, 3);
      check("back_to_back_remainder", remainder, 0);

      // Random regression
      for (int n = 0; n < 1000; n++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 255);
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = a >> $urandom_range(0, 8);
         endcase
         if (b == 0) b = 32'd1;
         model(a, b, eq, er, edbz);
         launch(a, b);
         wait_done(lat, bc);
         check("rand_quotient", quotient, eq);
         check("rand_remainder", remainder, er);
         check("rand_dbz", div_by_zero, edbz);
         check("rand_identity", {32'b0, quotient} * {32'b0, b} + {32'b0, remainder}, {32'b0, a});
         check("rand_rem_lt_divisor", remainder < b, 1);
         check("rand_latency", lat, 33);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
